// File: rtl/ycr1_pipe_wb_pkg.sv
// rtl/ycr1_pipe_wb_pkg.sv - shared types and constants for the MPRF writeback path
package ycr1_pipe_wb_pkg;

    localparam int YCR1_WB_FIFO_DEPTH = 2;
    localparam int YCR1_WB_AWIDTH     = 5;
    localparam int YCR1_WB_XLEN       = 32;

    typedef struct packed {
        logic [YCR1_WB_AWIDTH-1:0] rd;
        logic [YCR1_WB_XLEN-1:0]   data;
    } type_ycr1_wb_ent_s;

endpackage

// File: rtl/ycr1_pipe_mprf_wb_if.sv
// rtl/ycr1_pipe_mprf_wb_if.sv - push/pop and entry-visibility bundle of the ALU skid FIFO
interface ycr1_pipe_mprf_wb_if #(
    parameter int AWIDTH = 5,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2
);
    logic                           push;
    logic [AWIDTH-1:0]              push_rd;
    logic [XLEN-1:0]                push_data;
    logic                           pop;
    logic [AWIDTH-1:0]              head_rd;
    logic [XLEN-1:0]                head_data;
    logic                           empty;
    logic                           full;
    logic [DEPTH-1:0]               ent_vd;
    logic [DEPTH-1:0][AWIDTH-1:0]   ent_rd;

    modport master (
        output push, push_rd, push_data, pop,
        input  head_rd, head_data, empty, full, ent_vd, ent_rd
    );

    modport slave (
        input  push, push_rd, push_data, pop,
        output head_rd, head_data, empty, full, ent_vd, ent_rd
    );
endinterface

// File: rtl/ycr1_pipe_wb_fifo.sv
// rtl/ycr1_pipe_wb_fifo.sv - ALU result skid FIFO exposing every slot for hazard compare
module ycr1_pipe_wb_fifo
    import ycr1_pipe_wb_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int XLEN   = 32,
    parameter int DEPTH  = YCR1_WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ycr1_pipe_mprf_wb_if.slave    fifo_if
);
    localparam int PW = $clog2(DEPTH);

    logic [AWIDTH-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [PW:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (fifo_if.push) begin
                rd_q[wptr_q]   <= fifo_if.push_rd;
                data_q[wptr_q] <= fifo_if.push_data;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (fifo_if.pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(fifo_if.push) - (PW+1)'(fifo_if.pop);
        end
    end

    assign fifo_if.head_rd   = rd_q[rptr_q];
    assign fifo_if.head_data = data_q[rptr_q];
    assign fifo_if.empty     = (count_q == '0);
    assign fifo_if.full      = (count_q == (PW+1)'(DEPTH));

    // A slot is live when its distance from the read pointer is below the fill count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] off;
        assign off                = PW'(g) - rptr_q;
        assign fifo_if.ent_vd[g]  = ({1'b0, off} < count_q);
        assign fifo_if.ent_rd[g]  = rd_q[g];
    end

endmodule

// File: rtl/ycr1_pipe_mprf_wb.sv
// rtl/ycr1_pipe_mprf_wb.sv - merges ALU and LSU writebacks onto the MPRF write port
module ycr1_pipe_mprf_wb
    import ycr1_pipe_wb_pkg::*;
#(
    parameter int AWIDTH     = 5,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = YCR1_WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exu_alu_wb_vd_i,
    output logic              exu_alu_wb_rdy_o,
    input  logic [AWIDTH-1:0] exu_alu_rd_addr_i,
    input  logic [XLEN-1:0]   exu_alu_rd_data_i,
    input  logic              exu_ld_issue_i,
    input  logic [AWIDTH-1:0] exu_ld_rd_addr_i,
    input  logic              lsu_wb_vd_i,
    input  logic [AWIDTH-1:0] lsu_rd_addr_i,
    input  logic [XLEN-1:0]   lsu_rd_data_i,
    input  logic [AWIDTH-1:0] exu_rs1_addr_i,
    input  logic [AWIDTH-1:0] exu_rs2_addr_i,
    output logic              exu_rs1_hazard_o,
    output logic              exu_rs2_hazard_o,
    output logic              exu2mprf_w_req_o,
    output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
    output logic [XLEN-1:0]   exu2mprf_rd_data_o,
    output logic              wb_fifo_empty_o
);
    localparam int NREG = 2**AWIDTH;

    ycr1_pipe_mprf_wb_if #(.AWIDTH(AWIDTH), .XLEN(XLEN), .DEPTH(FIFO_DEPTH)) fifo_if ();

    ycr1_pipe_wb_fifo #(.AWIDTH(AWIDTH), .XLEN(XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (fifo_if)
    );

    logic              alu_wr;
    logic              lsu_wr;
    logic              bypass;
    logic              stage_vd;
    logic [AWIDTH-1:0] stage_rd;
    logic [XLEN-1:0]   stage_data;
    logic              w_req_q;
    logic [AWIDTH-1:0] rd_addr_q;
    logic [XLEN-1:0]   rd_data_q;
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;
    logic              fifo_hit1;
    logic              fifo_hit2;

    // rd==0 writes complete their handshake but never reach the FIFO or the port.
    assign exu_alu_wb_rdy_o  = ~fifo_if.full;
    assign alu_wr            = exu_alu_wb_vd_i & ~fifo_if.full & (|exu_alu_rd_addr_i);
    assign lsu_wr            = lsu_wb_vd_i & (|lsu_rd_addr_i);
    assign bypass            = alu_wr & ~lsu_wr & fifo_if.empty;
    assign fifo_if.pop       = ~lsu_wr & ~fifo_if.empty;
    assign fifo_if.push      = alu_wr & ~bypass;
    assign fifo_if.push_rd   = exu_alu_rd_addr_i;
    assign fifo_if.push_data = exu_alu_rd_data_i;

    always_comb begin
        stage_vd   = lsu_wr | fifo_if.pop | bypass;
        stage_rd   = exu_alu_rd_addr_i;
        stage_data = exu_alu_rd_data_i;
        if (lsu_wr) begin
            stage_rd   = lsu_rd_addr_i;
            stage_data = lsu_rd_data_i;
        end else if (fifo_if.pop) begin
            stage_rd   = fifo_if.head_rd;
            stage_data = fifo_if.head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_req_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            w_req_q <= stage_vd;
            if (stage_vd) begin
                rd_addr_q <= stage_rd;
                rd_data_q <= stage_data;
            end
        end
    end

    // A new issue to the same rd overrides the returning load's clear.
    always_comb begin
        pend_d = pend_q;
        if (lsu_wr) begin
            pend_d[lsu_rd_addr_i] = 1'b0;
        end
        if (exu_ld_issue_i) begin
            pend_d[exu_ld_rd_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_hit1 = fifo_hit1 | (fifo_if.ent_vd[i] & (fifo_if.ent_rd[i] == exu_rs1_addr_i));
            fifo_hit2 = fifo_hit2 | (fifo_if.ent_vd[i] & (fifo_if.ent_rd[i] == exu_rs2_addr_i));
        end
    end

    assign exu_rs1_hazard_o = (|exu_rs1_addr_i) & (pend_q[exu_rs1_addr_i] | fifo_hit1 |
                              (w_req_q & (rd_addr_q == exu_rs1_addr_i)));
    assign exu_rs2_hazard_o = (|exu_rs2_addr_i) & (pend_q[exu_rs2_addr_i] | fifo_hit2 |
                              (w_req_q & (rd_addr_q == exu_rs2_addr_i)));

    assign exu2mprf_w_req_o   = w_req_q;
    assign exu2mprf_rd_addr_o = rd_addr_q;
    assign exu2mprf_rd_data_o = rd_data_q;
    assign wb_fifo_empty_o    = fifo_if.empty;

endmodule

// File: tb/tb_ycr1_pipe_mprf_wb.sv
// tb/tb_ycr1_pipe_mprf_wb.sv - vector table, directed reset sequence and random model check
module tb_ycr1_pipe_mprf_wb;
    localparam int AW  = 5;
    localparam int XL  = 32;
    localparam int DEP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_vd = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [XL-1:0] alu_data = '0;
    logic          ld_iss = 1'b0;
    logic [AW-1:0] ld_rd = '0;
    logic          lsu_vd = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [XL-1:0] lsu_data = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          alu_rdy;
    logic          h1;
    logic          h2;
    logic          wreq;
    logic [AW-1:0] waddr;
    logic [XL-1:0] wdata;
    logic          empty;

    always #5 clk = ~clk;

    ycr1_pipe_mprf_wb #(.AWIDTH(AW), .XLEN(XL), .FIFO_DEPTH(DEP)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .exu_alu_wb_vd_i    (alu_vd),
        .exu_alu_wb_rdy_o   (alu_rdy),
        .exu_alu_rd_addr_i  (alu_rd),
        .exu_alu_rd_data_i  (alu_data),
        .exu_ld_issue_i     (ld_iss),
        .exu_ld_rd_addr_i   (ld_rd),
        .lsu_wb_vd_i        (lsu_vd),
        .lsu_rd_addr_i      (lsu_rd),
        .lsu_rd_data_i      (lsu_data),
        .exu_rs1_addr_i     (rs1),
        .exu_rs2_addr_i     (rs2),
        .exu_rs1_hazard_o   (h1),
        .exu_rs2_hazard_o   (h2),
        .exu2mprf_w_req_o   (wreq),
        .exu2mprf_rd_addr_o (waddr),
        .exu2mprf_rd_data_o (wdata),
        .wb_fifo_empty_o    (empty)
    );

    typedef struct {
        logic          avd;
        logic [AW-1:0] ard;
        logic [XL-1:0] adata;
        logic          lvd;
        logic [AW-1:0] lrd;
        logic [XL-1:0] ldata;
        logic          iss;
        logic [AW-1:0] ird;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          e_rdy;
        logic          e_wreq;
        logic [AW-1:0] e_addr;
        logic [XL-1:0] e_data;
        logic          e_h1;
        logic          e_h2;
        logic          e_empty;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [XL-1:0] data;
    } ent_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    ent_t          aq[$];
    bit            pend_m[32];
    logic          m_wreq;
    logic [AW-1:0] m_addr;
    logic [XL-1:0] m_data;

    function automatic vec_t mk(input logic avd, input logic [AW-1:0] ard, input logic [XL-1:0] adata,
                                input logic lvd, input logic [AW-1:0] lrd, input logic [XL-1:0] ldata,
                                input logic iss, input logic [AW-1:0] ird,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input logic e_rdy, input logic e_wreq, input logic [AW-1:0] e_addr,
                                input logic [XL-1:0] e_data, input logic e_h1, input logic e_h2,
                                input logic e_empty);
        vec_t v;
        v.avd = avd; v.ard = ard; v.adata = adata;
        v.lvd = lvd; v.lrd = lrd; v.ldata = ldata;
        v.iss = iss; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_wreq = e_wreq; v.e_addr = e_addr; v.e_data = e_data;
        v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rdy, input logic e_wreq,
                           input logic [AW-1:0] e_addr, input logic [XL-1:0] e_data,
                           input logic e_h1, input logic e_h2, input logic e_empty);
        chk({tag, ".rdy"},   32'(alu_rdy), 32'(e_rdy));
        chk({tag, ".wreq"},  32'(wreq),    32'(e_wreq));
        chk({tag, ".addr"},  32'(waddr),   32'(e_addr));
        chk({tag, ".data"},  wdata,        e_data);
        chk({tag, ".h1"},    32'(h1),      32'(e_h1));
        chk({tag, ".h2"},    32'(h2),      32'(e_h2));
        chk({tag, ".empty"}, 32'(empty),   32'(e_empty));
    endtask

    task automatic drive(input vec_t v);
        alu_vd = v.avd; alu_rd = v.ard; alu_data = v.adata;
        lsu_vd = v.lvd; lsu_rd = v.lrd; lsu_data = v.ldata;
        ld_iss = v.iss; ld_rd = v.ird;
        rs1 = v.r1; rs2 = v.r2;
    endtask

    task automatic idle_inputs();
        alu_vd = 1'b0; lsu_vd = 1'b0; ld_iss = 1'b0;
        alu_rd = '0; lsu_rd = '0; ld_rd = '0;
    endtask

    task automatic model_reset();
        aq.delete();
        foreach (pend_m[k]) pend_m[k] = 1'b0;
        m_wreq = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // One clock of the writeback rules: LSU first, then oldest queued ALU, then a fresh ALU result.
    task automatic model_step();
        bit            acc;
        bit            st;
        logic [AW-1:0] sa;
        logic [XL-1:0] sd;
        ent_t          e;
        acc = alu_vd && (aq.size() < DEP) && (alu_rd != 0);
        st  = 1'b0;
        sa  = '0;
        sd  = '0;
        if (lsu_vd && lsu_rd != 0) begin
            st = 1'b1; sa = lsu_rd; sd = lsu_data;
        end else if (aq.size() != 0) begin
            e = aq.pop_front();
            st = 1'b1; sa = e.rd; sd = e.data;
        end else if (acc) begin
            st = 1'b1; sa = alu_rd; sd = alu_data; acc = 1'b0;
        end
        if (acc) aq.push_back({alu_rd, alu_data});
        if (lsu_vd && lsu_rd != 0) pend_m[lsu_rd] = 1'b0;
        if (ld_iss && ld_rd != 0)  pend_m[ld_rd]  = 1'b1;
        m_wreq = st;
        if (st) begin
            m_addr = sa; m_data = sd;
        end
    endtask

    function automatic logic exp_haz(input logic [AW-1:0] rs);
        bit hit;
        hit = pend_m[rs] || (m_wreq && m_addr == rs);
        foreach (aq[k]) if (aq[k].rd == rs) hit = 1'b1;
        return (rs != 0) && hit;
    endfunction

    initial begin
        // c0..c5 bypass and collision, c6..c13 back-pressure, c14..c21 scoreboard, c22..c23 x0
        vt.push_back(mk(1, 5, 32'h1234, 0, 0, 0,          0, 0, 5, 0,   1, 0, 0,  32'h0,    0, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 5, 0,   1, 1, 5,  32'h1234, 1, 0, 1));
        vt.push_back(mk(1, 4, 32'hBBBB, 1, 3, 32'hAAAA,   0, 0, 4, 3,   1, 0, 5,  32'h1234, 0, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 4, 3,   1, 1, 3,  32'hAAAA, 1, 1, 0));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 4, 3,   1, 1, 4,  32'hBBBB, 1, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 4, 0,   1, 0, 4,  32'hBBBB, 0, 0, 1));
        vt.push_back(mk(1, 10, 32'hA0,  1, 1, 32'h11,     0, 0, 10, 1,  1, 0, 4,  32'hBBBB, 0, 0, 1));
        vt.push_back(mk(1, 11, 32'hA1,  1, 2, 32'h22,     0, 0, 10, 11, 1, 1, 1,  32'h11,   1, 0, 0));
        vt.push_back(mk(1, 12, 32'hA2,  1, 6, 32'h66,     0, 0, 12, 11, 0, 1, 2,  32'h22,   0, 1, 0));
        vt.push_back(mk(1, 12, 32'hA2,  0, 0, 0,          0, 0, 10, 12, 0, 1, 6,  32'h66,   1, 0, 0));
        vt.push_back(mk(1, 12, 32'hA2,  0, 0, 0,          0, 0, 10, 11, 1, 1, 10, 32'hA0,   1, 1, 0));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 12, 11, 1, 1, 11, 32'hA1,   1, 1, 0));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 12, 0,  1, 1, 12, 32'hA2,   1, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 12, 0,  1, 0, 12, 32'hA2,   0, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          1, 7, 0, 7,   1, 0, 12, 32'hA2,   0, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 0, 7,   1, 0, 12, 32'hA2,   0, 1, 1));
        vt.push_back(mk(0, 0, 0,        1, 7, 32'hCAFE,   0, 0, 0, 7,   1, 0, 12, 32'hA2,   0, 1, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 0, 7,   1, 1, 7,  32'hCAFE, 0, 1, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 0, 7,   1, 0, 7,  32'hCAFE, 0, 0, 1));
        vt.push_back(mk(0, 0, 0,        1, 9, 32'h99,     1, 9, 9, 0,   1, 0, 7,  32'hCAFE, 0, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 9, 0,   1, 1, 9,  32'h99,   1, 0, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 9, 0,   1, 0, 9,  32'h99,   1, 0, 1));
        vt.push_back(mk(1, 0, 32'hFFFF, 1, 0, 32'hEEEE,   1, 0, 0, 9,   1, 0, 9,  32'h99,   0, 1, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,          0, 0, 0, 0,   1, 0, 9,  32'h99,   0, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1, 0, 0, 32'h0, 0, 0, 1);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i]);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_wreq, vt[i].e_addr,
                    vt[i].e_data, vt[i].e_h1, vt[i].e_h2, vt[i].e_empty);
            @(posedge clk);
            #1;
        end

        // Reset mid-stream: two queued ALU entries and three pending loads
        drive(mk(1, 2, 32'h2, 1, 1, 32'h1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 4, 32'h4, 1, 3, 32'h3, 1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(0, 0, 32'h0, 1, 5, 32'h5, 1, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        idle_inputs();
        rs1 = 20; rs2 = 2;
        #1;
        chk_all("pre_rst", 0, 1, 5, 32'h5, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1, 0, 0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rs1 = 21; rs2 = 4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_all($sformatf("post_rst%0d", c), 1, 0, 0, 32'h0, 0, 0, 1);
        end

        // Randomized traffic against the reference model
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            alu_vd   = ($urandom_range(0, 9) < 6);
            alu_rd   = AW'($urandom_range(0, 7));
            alu_data = $urandom;
            lsu_vd   = ($urandom_range(0, 9) < 4);
            lsu_rd   = AW'($urandom_range(0, 7));
            lsu_data = $urandom;
            ld_iss   = ($urandom_range(0, 9) < 3);
            ld_rd    = AW'($urandom_range(0, 7));
            rs1      = AW'($urandom_range(0, 7));
            rs2      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            @(negedge clk);
            chk_all($sformatf("rnd%0d", c), (aq.size() < DEP), m_wreq, m_addr, m_data,
                    exp_haz(rs1), exp_haz(rs2), (aq.size() == 0));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
